// File: rtl/mux_scan_ctrl.sv
// Round-robin scan controller for a 4:1 mux: steps sel over channels 0..3, samples mux_out
// after a configurable dwell and publishes the assembled 4-bit word once per sweep.
module mux_scan_ctrl #(
  parameter int unsigned DWELL = 4,
  parameter int unsigned CNT_W = 8
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       start,
  input  logic       cont,
  input  logic       mux_out,
  output logic [1:0] sel,
  output logic [3:0] sample,
  output logic       valid,
  output logic       busy,
  output logic [7:0] sweeps
);

  if ((DWELL < 1) || (DWELL > 255)) begin : g_bad_dwell
    $error("mux_scan_ctrl: DWELL must be in 1..255");
  end
  if ((CNT_W < 32) && ((64'(1) << CNT_W) <= 64'(DWELL))) begin : g_bad_cnt_w
    $error("mux_scan_ctrl: CNT_W too narrow for DWELL");
  end

  localparam logic [CNT_W-1:0] CntLast = CNT_W'(DWELL - 1);

  typedef enum logic [0:0] {
    StIdle,
    StScan
  } state_e;

  state_e           state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [1:0]       sel_q, sel_d;
  logic [2:0]       shadow_q, shadow_d;
  logic [3:0]       sample_q, sample_d;
  logic             valid_q, valid_d;
  logic [7:0]       sweeps_q, sweeps_d;
  logic             capture;

  assign capture = (cnt_q == CntLast);

  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    sel_d    = sel_q;
    shadow_d = shadow_q;
    sample_d = sample_q;
    valid_d  = 1'b0;
    sweeps_d = sweeps_q;

    unique case (state_q)
      StIdle: begin
        sel_d = 2'd0;
        cnt_d = '0;
        if (start) begin
          state_d = StScan;
        end
      end
      StScan: begin
        if (!capture) begin
          cnt_d = cnt_q + 1'b1;
        end else begin
          cnt_d = '0;
          unique case (sel_q)
            2'd0: shadow_d[0] = mux_out;
            2'd1: shadow_d[1] = mux_out;
            2'd2: shadow_d[2] = mux_out;
            2'd3: begin
              // Last channel goes straight into the published word, no shadow stage.
              sample_d = {mux_out, shadow_q};
              valid_d  = 1'b1;
              sweeps_d = sweeps_q + 8'd1;
            end
            default: ;
          endcase
          if (sel_q != 2'd3) begin
            sel_d = sel_q + 2'd1;
          end else begin
            sel_d = 2'd0;
            if (!cont) begin
              state_d = StIdle;
            end
          end
        end
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= StIdle;
      cnt_q    <= '0;
      sel_q    <= 2'd0;
      shadow_q <= 3'd0;
      sample_q <= 4'd0;
      valid_q  <= 1'b0;
      sweeps_q <= 8'd0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      sel_q    <= sel_d;
      shadow_q <= shadow_d;
      sample_q <= sample_d;
      valid_q  <= valid_d;
      sweeps_q <= sweeps_d;
    end
  end

  assign sel    = sel_q;
  assign sample = sample_q;
  assign valid  = valid_q;
  assign busy   = (state_q == StScan);
  assign sweeps = sweeps_q;

endmodule

// File: tb/tb_mux_scan_ctrl.sv
// Directed bench for mux_scan_ctrl: a DWELL=4 and a DWELL=1 instance, each with a sample
// scoreboard fed by the stimulus and drained whenever valid pulses.
module tb_mux_scan_ctrl;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_bad = 0;
  int cyc   = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // Instance A: DWELL=4
  logic       rst_a = 1'b0, start_a = 1'b0, cont_a = 1'b0;
  logic [3:0] in_a = 4'd0;
  logic       mux_a;
  logic [1:0] sel_a;
  logic [3:0] sample_a;
  logic       valid_a, busy_a;
  logic [7:0] sweeps_a;
  assign mux_a = in_a[sel_a];

  mux_scan_ctrl #(.DWELL(4), .CNT_W(8)) u_dut_a (
    .clk(clk), .rst_n(rst_a), .start(start_a), .cont(cont_a), .mux_out(mux_a),
    .sel(sel_a), .sample(sample_a), .valid(valid_a), .busy(busy_a), .sweeps(sweeps_a)
  );

  // Instance B: DWELL=1
  logic       rst_b = 1'b0, start_b = 1'b0, cont_b = 1'b0;
  logic [3:0] in_b = 4'd0;
  logic       mux_b;
  logic [1:0] sel_b;
  logic [3:0] sample_b;
  logic       valid_b, busy_b;
  logic [7:0] sweeps_b;
  assign mux_b = in_b[sel_b];

  mux_scan_ctrl #(.DWELL(1), .CNT_W(8)) u_dut_b (
    .clk(clk), .rst_n(rst_b), .start(start_b), .cont(cont_b), .mux_out(mux_b),
    .sel(sel_b), .sample(sample_b), .valid(valid_b), .busy(busy_b), .sweeps(sweeps_b)
  );

  logic [3:0] qa[$];
  logic [3:0] qb[$];
  int         va_times[$];

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  always @(negedge clk) begin
    if (rst_a && valid_a) begin
      va_times.push_back(cyc);
      if (qa.size() == 0) chk("a_unexpected_valid", {31'd0, valid_a}, 32'd0);
      else chk("a_sample", {28'd0, sample_a}, {28'd0, qa.pop_front()});
    end
    if (rst_b && valid_b) begin
      if (qb.size() == 0) chk("b_unexpected_valid", {31'd0, valid_b}, 32'd0);
      else chk("b_sample", {28'd0, sample_b}, {28'd0, qb.pop_front()});
    end
  end

  initial begin
    // Reset held while start toggles
    for (int i = 0; i < 4; i++) begin
      start_a = (i % 2 == 1);
      start_b = (i % 2 == 1);
      tick();
      chk("a_in_reset", {16'd0, sel_a, sample_a, valid_a, busy_a, sweeps_a}, 32'd0);
      chk("b_in_reset", {16'd0, sel_b, sample_b, valid_b, busy_b, sweeps_b}, 32'd0);
    end
    start_a = 1'b0;
    start_b = 1'b0;
    #2;
    rst_a = 1'b1;
    rst_b = 1'b1;
    repeat (3) tick();
    chk("a_idle_after_reset", {30'd0, busy_a, valid_a}, 32'd0);
    chk("a_sel_idle", {30'd0, sel_a}, 32'd0);

    // Single shot, DWELL=4
    in_a = 4'b1010;
    cont_a = 1'b0;
    qa.push_back(4'b1010);
    start_a = 1'b1;
    tick();
    start_a = 1'b0;
    chk("a_ss_busy_e0", {31'd0, busy_a}, 32'd1);
    chk("a_ss_sel_e0", {30'd0, sel_a}, 32'd0);
    for (int k = 1; k <= 16; k++) begin
      tick();
      chk("a_ss_sel", {30'd0, sel_a}, (k < 16) ? 32'(k / 4) : 32'd0);
      chk("a_ss_busy", {31'd0, busy_a}, (k < 16) ? 32'd1 : 32'd0);
    end
    chk("a_ss_valid_e16", {31'd0, valid_a}, 32'd1);
    chk("a_ss_sweeps", {24'd0, sweeps_a}, 32'd1);
    tick();
    chk("a_ss_valid_pulse", {31'd0, valid_a}, 32'd0);

    // Continuous, three sweeps, input change mid-sweep 2, cont dropped in sweep 3
    chk("a_sample_held", {28'd0, sample_a}, 32'hA);
    in_a = 4'b0110;
    cont_a = 1'b1;
    qa.push_back(4'b0110);
    qa.push_back(4'b1000);  // ch0 captured at E20 before change, ch1..3 after
    qa.push_back(4'b1001);
    va_times.delete();
    start_a = 1'b1;
    tick();
    start_a = 1'b0;
    chk("a_c_sample_not_cleared", {28'd0, sample_a}, 32'hA);
    for (int k = 1; k <= 48; k++) begin
      start_a = (k == 6) || (k == 48);
      if (k == 23) in_a = 4'b1001;
      if (k == 41) cont_a = 1'b0;
      tick();
      if (k == 16 || k == 32) chk("a_c_busy_sweep_end", {31'd0, busy_a}, 32'd1);
      if (k == 17 || k == 33) chk("a_c_no_gap_sel", {30'd0, sel_a}, 32'd0);
    end
    start_a = 1'b0;
    chk("a_c_busy_end", {31'd0, busy_a}, 32'd0);
    chk("a_c_sweeps", {24'd0, sweeps_a}, 32'd4);
    chk("a_c_sel_end", {30'd0, sel_a}, 32'd0);
    repeat (3) tick();
    chk("a_c_start_at_end_ignored", {31'd0, busy_a}, 32'd0);
    chk("a_c_nvalid", 32'(va_times.size()), 32'd3);
    if (va_times.size() == 3) begin
      chk("a_c_gap1", 32'(va_times[1] - va_times[0]), 32'd16);
      chk("a_c_gap2", 32'(va_times[2] - va_times[1]), 32'd16);
    end

    // Reset mid-sweep while sel==2
    in_a = 4'b1111;
    start_a = 1'b1;
    tick();
    start_a = 1'b0;
    repeat (8) tick();
    chk("a_mr_sel2", {30'd0, sel_a}, 32'd2);
    #1;
    rst_a = 1'b0;
    #1;
    chk("a_mr_async_clear", {16'd0, sel_a, sample_a, valid_a, busy_a, sweeps_a}, 32'd0);
    repeat (2) tick();
    chk("a_mr_held", {16'd0, sel_a, sample_a, valid_a, busy_a, sweeps_a}, 32'd0);
    #2;
    rst_a = 1'b1;
    in_a = 4'b0101;
    qa.push_back(4'b0101);
    start_a = 1'b1;
    tick();
    start_a = 1'b0;
    chk("a_mr_restart_sel", {30'd0, sel_a}, 32'd0);
    chk("a_mr_restart_busy", {31'd0, busy_a}, 32'd1);
    repeat (16) tick();
    chk("a_mr_sweeps", {24'd0, sweeps_a}, 32'd1);
    chk("a_mr_busy_end", {31'd0, busy_a}, 32'd0);

    // DWELL=1: sel every cycle, start re-pulsed while busy
    in_b = 4'b1101;
    cont_b = 1'b0;
    qb.push_back(4'b1101);
    start_b = 1'b1;
    tick();
    start_b = 1'b0;
    chk("b_sel_e0", {30'd0, sel_b}, 32'd0);
    for (int k = 1; k <= 4; k++) begin
      start_b = (k == 2);
      tick();
      chk("b_sel", {30'd0, sel_b}, (k < 4) ? 32'(k) : 32'd0);
      chk("b_busy", {31'd0, busy_b}, (k < 4) ? 32'd1 : 32'd0);
    end
    start_b = 1'b0;
    chk("b_valid_e4", {31'd0, valid_b}, 32'd1);
    chk("b_sample_e4", {28'd0, sample_b}, 32'hD);
    tick();
    chk("b_repulse_ignored", {31'd0, busy_b}, 32'd0);
    chk("b_sweeps", {24'd0, sweeps_b}, 32'd1);

    // 256 continuous sweeps wrap the counter
    #2;
    rst_b = 1'b0;
    #1;
    rst_b = 1'b1;
    in_b = 4'b0011;
    cont_b = 1'b1;
    for (int i = 0; i < 256; i++) qb.push_back(4'b0011);
    start_b = 1'b1;
    tick();
    start_b = 1'b0;
    for (int k = 1; k <= 1024; k++) begin
      if (k == 1021) cont_b = 1'b0;
      tick();
      if (k == 1020) chk("b_sweeps_255", {24'd0, sweeps_b}, 32'd255);
    end
    chk("b_sweeps_wrap", {24'd0, sweeps_b}, 32'd0);
    chk("b_wrap_busy_end", {31'd0, busy_b}, 32'd0);
    repeat (2) tick();

    chk("a_scoreboard_drained", 32'(qa.size()), 32'd0);
    chk("b_scoreboard_drained", 32'(qb.size()), 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
